wl_expand: RTL and testbench

//   Word-length expander: takes IW-bit samples produced by the floor/truncation stage
//   and restores them to an OW-bit datapath (OW > IW) for downstream arithmetic.

---
 rtl/wl_expand.sv | 132 +++++++++++++
 tb/tb_wl_expand.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wl_expand.sv
// Word-length expander: widens IW-bit samples to OW bits (MSB- or LSB-aligned), 2-entry skid buffer.
// Latency: 1 cycle from accept to out_data when unstalled; one word per cycle sustained.
// Backpressure: in_ready is registered and drops only once both buffer entries are occupied.
// Optional feature: define WL_EXPAND_DITHER_EN to fill the MSB-aligned low bits from a 16-bit LFSR.
module wl_expand #(
    parameter int IW      = 14,
    parameter int OW      = 16,
    parameter bit SIGNED  = 1'b1,
    parameter bit JUSTIFY = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_last
);

    localparam int F = OW - IW;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t        state;
    logic [OW-1:0] skid_data;
    logic          skid_last;
    logic [OW-1:0] exp_data;
    logic [F-1:0]  fill;
    logic          accept;
    logic          drain;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

`ifdef WL_EXPAND_DITHER_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR map to bits 0,2,3,5.
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign fill    = lfsr[F-1:0];

    // Dither source steps only when a word is actually accepted, so stalls do not consume noise.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (accept) begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
        end
    end
`else
    assign fill = '0;
`endif

    // Widen at accept time so both buffer entries hold finished OW-bit words.
    always_comb begin
        exp_data = '0;
        if (!JUSTIFY) begin
            exp_data = {in_data, fill};
        end else if (SIGNED) begin
            exp_data = {{F{in_data[IW-1]}}, in_data};
        end else begin
            exp_data = {{F{1'b0}}, in_data};
        end
    end

    // Skid-buffer FSM: out_data is the head entry, skid_* holds the second word while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            skid_data <= '0;
            skid_last <= 1'b0;
        end else begin
            case (state)
                S_EMPTY: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        out_data  <= exp_data;
                        out_last  <= in_last;
                        out_valid <= 1'b1;
                        state     <= S_ONE;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                S_ONE: begin
                    in_ready <= 1'b1;
                    if (accept && drain) begin
                        out_data <= exp_data;
                        out_last <= in_last;
                    end else if (accept) begin
                        skid_data <= exp_data;
                        skid_last <= in_last;
                        in_ready  <= 1'b0;
                        state     <= S_FULL;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                        state     <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drain) begin
                        out_data <= skid_data;
                        out_last <= skid_last;
                        in_ready <= 1'b1;
                        state    <= S_ONE;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wl_expand.sv
// Directed bench for wl_expand: reset, width rules, backpressure, throughput, random flow, dither.
// The main instance is MSB-aligned; two LSB-aligned instances share its inputs.
// Every comparison steps checks; failures step errors and print a FAIL line.
module tb_wl_expand;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [13:0] in_data = '0;

    logic        in_ready, out_valid, out_last;
    logic [15:0] out_data;
    logic        sx_in_ready, sx_out_valid, sx_out_last;
    logic [15:0] sx_out_data;
    logic        zx_in_ready, zx_out_valid, zx_out_last;
    logic [15:0] zx_out_data;

    int errors = 0;
    int checks = 0;

    logic [15:0] q_data[$];
    logic        q_last[$];

    always #5 clk = ~clk;

    wl_expand #(.IW(14), .OW(16), .SIGNED(1'b1), .JUSTIFY(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    wl_expand #(.IW(14), .OW(16), .SIGNED(1'b1), .JUSTIFY(1'b1)) u_sx (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sx_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(sx_out_valid),
        .out_ready(out_ready), .out_data(sx_out_data), .out_last(sx_out_last)
    );

    wl_expand #(.IW(14), .OW(16), .SIGNED(1'b0), .JUSTIFY(1'b1)) u_zx (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(zx_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(zx_out_valid),
        .out_ready(out_ready), .out_data(zx_out_data), .out_last(zx_out_last)
    );

    function automatic logic [15:0] msb_word(input logic [13:0] w);
        return {w, 2'b00};
    endfunction

    // Record what transfers at the coming edge, then advance to 1 time unit past it.
    task automatic tick(output bit acc, output bit drn, output logic [15:0] d, output logic l);
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        d   = out_data;
        l   = out_last;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 14'h1234; in_last = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || out_data !== 16'h0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: valid=%b data=%h ready=%b, want 0/0000/0",
                         i, out_valid, out_data, in_ready);
            end
        end
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_msb_align();
        bit acc, drn; logic [15:0] d; logic l;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 14'h2ABC;
        tick(acc, drn, d, l);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hAAF0) begin
            errors++;
            $display("FAIL msb_align: valid=%b data=%h, want 1/aaf0", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick(acc, drn, d, l);
        checks++;
        if (drn !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL msb_drain: drained=%b valid_after=%b, want 1/0", drn, out_valid);
        end
    endtask

    task automatic test_lsb_extend();
        bit acc, drn; logic [15:0] d; logic l;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 14'h3FFF;
        tick(acc, drn, d, l);
        checks++;
        if (sx_out_data !== 16'hFFFF || zx_out_data !== 16'h3FFF || out_data !== 16'hFFFC) begin
            errors++;
            $display("FAIL extend_3fff: sx=%h zx=%h msb=%h, want ffff/3fff/fffc",
                     sx_out_data, zx_out_data, out_data);
        end
        in_data = 14'h1FFF;
        tick(acc, drn, d, l);
        checks++;
        if (sx_out_data !== 16'h1FFF || zx_out_data !== 16'h1FFF || out_data !== 16'h7FFC) begin
            errors++;
            $display("FAIL extend_1fff: sx=%h zx=%h msb=%h, want 1fff/1fff/7ffc",
                     sx_out_data, zx_out_data, out_data);
        end
        in_valid = 1'b0;
        tick(acc, drn, d, l);
        checks++;
        if (out_valid !== 1'b0 || sx_out_valid !== 1'b0 || zx_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL extend_empty: valid=%b%b%b, want 000", out_valid, sx_out_valid, zx_out_valid);
        end
    endtask

    task automatic test_backpressure();
        bit acc, drn; logic [15:0] d; logic l;
        int word = 1, n_acc = 0, n_drn = 0, cyc = 0;
        logic [15:0] ed; logic el;
        q_data.delete(); q_last.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 14'(word); in_last = (word == 3);
            tick(acc, drn, d, l);
            if (acc) begin
                q_data.push_back(msb_word(14'(word))); q_last.push_back(word == 3);
                word++; n_acc++;
            end
        end
        checks++;
        if (n_acc !== 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: accepts=%0d ready=%b, want 2/0", n_acc, in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0004) begin
            errors++;
            $display("FAIL bp_hold: valid=%b data=%h, want 1/0004", out_valid, out_data);
        end
        out_ready = 1'b1;
        while (n_drn < 6 && cyc < 50) begin
            in_valid = (word <= 6); in_data = 14'(word); in_last = (word == 3);
            tick(acc, drn, d, l);
            if (acc) begin
                q_data.push_back(msb_word(14'(word))); q_last.push_back(word == 3);
                word++;
            end
            if (drn) begin
                n_drn++;
                ed = (q_data.size() > 0) ? q_data.pop_front() : 16'hxxxx;
                el = (q_last.size() > 0) ? q_last.pop_front() : 1'bx;
                checks++;
                if (d !== ed || l !== el) begin
                    errors++;
                    $display("FAIL bp_order #%0d: data=%h last=%b, want %h/%b", n_drn, d, l, ed, el);
                end
            end
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if (n_drn !== 6 || q_data.size() !== 0) begin
            errors++;
            $display("FAIL bp_count: drained=%0d left=%0d, want 6/0", n_drn, q_data.size());
        end
    endtask

    task automatic test_back_to_back();
        bit acc, drn; logic [15:0] d; logic l;
        int n_acc = 0, n_drn = 0;
        logic [15:0] ed;
        q_data.delete();
        out_ready = 1'b1; in_last = 1'b0;
        for (int i = 0; i < 21; i++) begin
            in_valid = (i < 20); in_data = 14'(100 + i);
            tick(acc, drn, d, l);
            if (acc) begin
                q_data.push_back(msb_word(14'(100 + i))); n_acc++;
            end
            if (drn) begin
                n_drn++;
                ed = (q_data.size() > 0) ? q_data.pop_front() : 16'hxxxx;
                checks++;
                if (d !== ed) begin
                    errors++;
                    $display("FAIL b2b_data #%0d: data=%h, want %h", n_drn, d, ed);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (n_acc !== 20 || n_drn !== 20) begin
            errors++;
            $display("FAIL b2b_rate: accepts=%0d drains=%0d in 21 cycles, want 20/20", n_acc, n_drn);
        end
    endtask

    task automatic test_random();
        bit acc, drn; logic [15:0] d; logic l;
        int sent = 0, got = 0, cyc = 0;
        logic [15:0] ed; logic el; logic [13:0] w;
        q_data.delete(); q_last.delete();
        while (got < 10000 && cyc < 60000) begin
            in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            w = 14'($urandom); in_data = w; in_last = 1'($urandom);
            tick(acc, drn, d, l);
            if (acc) begin
                q_data.push_back(msb_word(w)); q_last.push_back(in_last); sent++;
            end
            if (drn) begin
                got++;
                ed = (q_data.size() > 0) ? q_data.pop_front() : 16'hxxxx;
                el = (q_last.size() > 0) ? q_last.pop_front() : 1'bx;
                checks++;
                if (d !== ed || l !== el) begin
                    errors++;
                    $display("FAIL rand #%0d: data=%h last=%b, want %h/%b", got, d, l, ed, el);
                end
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 10000 || q_data.size() !== 0) begin
            errors++;
            $display("FAIL rand_count: drained=%0d left=%0d in %0d cycles, want 10000/0", got, q_data.size(), cyc);
        end
    endtask

    task automatic test_reset_mid();
        bit acc, drn; logic [15:0] d; logic l;
        out_ready = 1'b0; in_valid = 1'b1; in_last = 1'b0;
        in_data = 14'h00AA; tick(acc, drn, d, l);
        in_data = 14'h00BB; tick(acc, drn, d, l);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b ready=%b, want 0/0", out_valid, in_ready);
        end
        rst = 1'b0; in_valid = 1'b0;
        tick(acc, drn, d, l);
        in_valid = 1'b1; in_data = 14'h00CC; out_ready = 1'b1;
        tick(acc, drn, d, l);
        in_valid = 1'b0;
        tick(acc, drn, d, l);
        checks++;
        if (drn !== 1'b1 || d !== 16'h0330 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_fresh: drained=%b data=%h valid_after=%b, want 1/0330/0", drn, d, out_valid);
        end
    endtask

`ifdef WL_EXPAND_DITHER_EN
    task automatic test_dither();
        bit acc, drn; logic [15:0] d; logic l;
        logic [15:0] exp_tab[5] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0002};
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = 14'h0000;
            tick(acc, drn, d, l);
            in_valid = 1'b0;
            tick(acc, drn, d, l);
            checks++;
            if (drn !== 1'b1 || d !== exp_tab[k]) begin
                errors++;
                $display("FAIL dither #%0d: drained=%b data=%h, want 1/%h", k, drn, d, exp_tab[k]);
            end
            repeat (2) tick(acc, drn, d, l);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef WL_EXPAND_DITHER_EN
        test_dither();
`else
        test_msb_align();
        test_lsb_extend();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
